// File: rtl/ptw_pkg.sv
// Shared types for the PTW memory responder: FSM states, PTE buffer entry layout
// and the PTE alignment constant.
package ptw_pkg;

    localparam int PTE_ALIGN_BITS  = 3;
    localparam int PTW_PADDR_WIDTH = 64;
    localparam int PTW_DATA_WIDTH  = 64;
    localparam int PTW_TAG_WIDTH   = PTW_PADDR_WIDTH - PTE_ALIGN_BITS;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_LOOKUP   = 3'd2,
        S_MEM_REQ  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_RESPOND  = 3'd5,
        S_DRAIN    = 3'd6
    } ptw_rsp_state_t;

    typedef struct packed {
        logic                        valid;
        logic [PTW_PADDR_WIDTH-4:0]  tag;
        logic [PTW_DATA_WIDTH-1:0]   data;
    } pte_buf_entry_t;

endpackage

// File: rtl/ptw_pte_buf.sv
// Small fully-associative PTE buffer: combinational lookup, round-robin fill,
// flush of all valid bits (flush beats a coincident fill).
module ptw_pte_buf
    import ptw_pkg::*;
#(
    parameter int PADDR_WIDTH = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUF_ENTRIES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PADDR_WIDTH-PTE_ALIGN_BITS-1:0] lookup_tag,
    output logic                                 hit,
    output logic [DATA_WIDTH-1:0]                hit_data,
    input  logic                                 fill_en,
    input  logic [PADDR_WIDTH-PTE_ALIGN_BITS-1:0] fill_tag,
    input  logic [DATA_WIDTH-1:0]                fill_data,
    input  logic                                 flush
);

    localparam int PTR_W = $clog2(BUF_ENTRIES);

    pte_buf_entry_t   entries_r [BUF_ENTRIES];
    logic [PTR_W-1:0] ptr_r;
    logic             match_s;

    // Parallel tag compare across all entries; at most one entry can match.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        match_s  = 1'b0;
        for (int i = 0; i < BUF_ENTRIES; i++) begin
            match_s  = entries_r[i].valid && (entries_r[i].tag == PTW_TAG_WIDTH'(lookup_tag));
            hit      = hit | match_s;
            hit_data = hit_data | (match_s ? DATA_WIDTH'(entries_r[i].data) : '0);
        end
    end

    // Entry storage and replacement pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_ENTRIES; i++) begin
                entries_r[i] <= '0;
            end
            ptr_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < BUF_ENTRIES; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else if (fill_en) begin
            entries_r[ptr_r].valid <= 1'b1;
            entries_r[ptr_r].tag   <= PTW_TAG_WIDTH'(fill_tag);
            entries_r[ptr_r].data  <= PTW_DATA_WIDTH'(fill_data);
            ptr_r                  <= ptr_r + 1'b1;
        end
    end

endmodule

// File: rtl/ptw_mem_responder.sv
// PTW memory-side responder: serves single-PTE reads from a small buffer or the
// memory read channel, with timeout recovery that drains the late response.
module ptw_mem_responder
    import ptw_pkg::*;
#(
    parameter int PADDR_WIDTH    = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_LAG       = 1,
    parameter int BUF_ENTRIES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ptw_req,
    input  logic [PADDR_WIDTH-1:0] ptw_addr,
    output logic [DATA_WIDTH-1:0]  ptw_data,
    output logic                   ptw_ready,
    output logic                   ptw_err,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [PADDR_WIDTH-1:0] mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]  mem_resp_data,
    input  logic                   mem_resp_err,
    input  logic                   buf_flush,
    output logic                   busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ptw_rsp_state_t         state_r;
    logic [PADDR_WIDTH-1:0] addr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   tmo_r;
    logic                   pend_r;
    logic                   lag_r;
    logic                   hit_s;
    logic [DATA_WIDTH-1:0]  hit_data_s;
    logic                   fill_en_s;

    assign fill_en_s = (state_r == S_MEM_WAIT) && mem_resp_valid && !mem_resp_err;

    ptw_pte_buf #(
        .PADDR_WIDTH (PADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .BUF_ENTRIES (BUF_ENTRIES)
    ) u_pte_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (addr_r[PADDR_WIDTH-1:PTE_ALIGN_BITS]),
        .hit        (hit_s),
        .hit_data   (hit_data_s),
        .fill_en    (fill_en_s),
        .fill_tag   (addr_r[PADDR_WIDTH-1:PTE_ALIGN_BITS]),
        .fill_data  (mem_resp_data),
        .flush      (buf_flush)
    );

    // Walk FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            addr_r        <= '0;
            cnt_r         <= '0;
            tmo_r         <= 1'b0;
            pend_r        <= 1'b0;
            lag_r         <= 1'b0;
            ptw_data      <= '0;
            ptw_ready     <= 1'b0;
            ptw_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            busy          <= 1'b0;
        end else begin
            ptw_ready <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // A request queued during DRAIN takes priority; lag_r means its
                    // address is on the bus in this very cycle.
                    if (pend_r) begin
                        pend_r  <= 1'b0;
                        lag_r   <= 1'b0;
                        if (lag_r) begin
                            addr_r <= ptw_addr;
                        end
                        state_r <= S_LOOKUP;
                        busy    <= 1'b1;
                    end else if (ptw_req) begin
                        busy <= 1'b1;
                        if (ADDR_LAG == 0) begin
                            addr_r  <= ptw_addr;
                            state_r <= S_LOOKUP;
                        end else begin
                            state_r <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    addr_r  <= ptw_addr;
                    state_r <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (addr_r[PTE_ALIGN_BITS-1:0] != 3'b000) begin
                        ptw_data  <= '0;
                        ptw_err   <= 1'b1;
                        ptw_ready <= 1'b1;
                        state_r   <= S_RESPOND;
                    end else if (hit_s) begin
                        ptw_data  <= hit_data_s;
                        ptw_err   <= 1'b0;
                        ptw_ready <= 1'b1;
                        state_r   <= S_RESPOND;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {addr_r[PADDR_WIDTH-1:PTE_ALIGN_BITS], 3'b000};
                        state_r       <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt_r         <= '0;
                        state_r       <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        ptw_data  <= mem_resp_data;
                        ptw_err   <= mem_resp_err;
                        ptw_ready <= 1'b1;
                        state_r   <= S_RESPOND;
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ptw_data  <= '0;
                        ptw_err   <= 1'b1;
                        ptw_ready <= 1'b1;
                        tmo_r     <= 1'b1;
                        state_r   <= S_RESPOND;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                S_RESPOND: begin
                    tmo_r   <= 1'b0;
                    busy    <= tmo_r;
                    state_r <= tmo_r ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (ptw_req && !pend_r) begin
                        pend_r <= 1'b1;
                        if (ADDR_LAG == 0) begin
                            addr_r <= ptw_addr;
                        end else begin
                            lag_r <= 1'b1;
                        end
                    end else if (lag_r) begin
                        addr_r <= ptw_addr;
                        lag_r  <= 1'b0;
                    end
                    if (mem_resp_valid) begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed self-checking bench for ptw_mem_responder (ADDR_LAG=1, TIMEOUT_CYCLES=8).
module tb_ptw_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ptw_req;
    logic [63:0] ptw_addr;
    logic [63:0] ptw_data;
    logic        ptw_ready;
    logic        ptw_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        mem_resp_err;
    logic        buf_flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_0000_0000;

    ptw_mem_responder #(
        .PADDR_WIDTH    (64),
        .DATA_WIDTH     (64),
        .ADDR_LAG       (1),
        .BUF_ENTRIES    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ptw_req        (ptw_req),
        .ptw_addr       (ptw_addr),
        .ptw_data       (ptw_data),
        .ptw_ready      (ptw_ready),
        .ptw_err        (ptw_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .buf_flush      (buf_flush),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Strobe, then present the real address one cycle later; ends in LOOKUP.
    task automatic issue(input logic [63:0] a);
        ptw_req  = 1'b1;
        ptw_addr = GARBAGE;
        step();
        ptw_req  = 1'b0;
        ptw_addr = a;
        step();
    endtask

    task automatic do_hit(input string tag, input logic [63:0] a, input logic [63:0] d);
        issue(a);
        step();
        check({tag, "_rdy"}, {63'd0, ptw_ready}, 64'd1);
        check({tag, "_data"}, ptw_data, d);
        check({tag, "_err"}, {63'd0, ptw_err}, 64'd0);
        check({tag, "_nomem"}, {63'd0, mem_req_valid}, 64'd0);
        step();
        check({tag, "_pulse"}, {63'd0, ptw_ready}, 64'd0);
    endtask

    task automatic do_miss(input string tag, input logic [63:0] a, input logic [63:0] d,
                           input logic e, input int stall, input logic flush_at_resp);
        issue(a);
        step();
        check({tag, "_mreq"}, {63'd0, mem_req_valid}, 64'd1);
        check({tag, "_maddr"}, mem_req_addr, a);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_hold_v"}, {63'd0, mem_req_valid}, 64'd1);
            check({tag, "_hold_a"}, mem_req_addr, a);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check({tag, "_mreq_drop"}, {63'd0, mem_req_valid}, 64'd0);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        mem_resp_err   = e;
        buf_flush      = flush_at_resp;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        buf_flush      = 1'b0;
        check({tag, "_rdy"}, {63'd0, ptw_ready}, 64'd1);
        check({tag, "_data"}, ptw_data, d);
        check({tag, "_err"}, {63'd0, ptw_err}, {63'd0, e});
        step();
        check({tag, "_pulse"}, {63'd0, ptw_ready}, 64'd0);
        check({tag, "_hold_d"}, ptw_data, d);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        ptw_req        = 1'b0;
        ptw_addr       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_err   = 1'b0;
        buf_flush      = 1'b0;
        step();
        step();
        check("rst_ready", {63'd0, ptw_ready}, 64'd0);
        check("rst_err", {63'd0, ptw_err}, 64'd0);
        check("rst_mreq", {63'd0, mem_req_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_data", ptw_data, 64'd0);
        check("rst_maddr", mem_req_addr, 64'd0);
        rst_n = 1'b1;
        step();

        // Miss then hit on the same PTE.
        do_miss("miss1", 64'h0000_0000_8000_1008, 64'h0000_0000_2000_0C01, 1'b0, 0, 1'b0);
        do_hit("hit1", 64'h0000_0000_8000_1008, 64'h0000_0000_2000_0C01);

        // Misaligned address answers with an error and never touches memory.
        issue(64'h0000_0000_8000_1004);
        step();
        check("mis_rdy", {63'd0, ptw_ready}, 64'd1);
        check("mis_err", {63'd0, ptw_err}, 64'd1);
        check("mis_data", ptw_data, 64'd0);
        check("mis_nomem", {63'd0, mem_req_valid}, 64'd0);
        step();

        // Backpressure plus bus error: no fill, so the retry misses again.
        do_miss("bperr", 64'h0000_0000_8000_2000, 64'h0000_0000_0000_1111, 1'b1, 5, 1'b0);
        do_miss("retry", 64'h0000_0000_8000_2000, 64'h0000_0000_0000_2222, 1'b0, 0, 1'b0);
        do_hit("hit2", 64'h0000_0000_8000_2000, 64'h0000_0000_0000_2222);

        // Flush in IDLE invalidates a previously cached PTE.
        buf_flush = 1'b1;
        step();
        buf_flush = 1'b0;
        do_miss("postfl", 64'h0000_0000_8000_1008, 64'h0000_0000_0000_5555, 1'b0, 0, 1'b0);

        // Five fills into four entries evict the oldest.
        for (int i = 0; i < 5; i++) begin
            do_miss($sformatf("fill%0d", i), 64'h0000_0000_9000_0000 + 64'(i * 8),
                    64'h0000_0000_0000_A000 + 64'(i), 1'b0, 0, 1'b0);
        end
        do_hit("rep_hit4", 64'h0000_0000_9000_0020, 64'h0000_0000_0000_A004);
        do_hit("rep_hit1", 64'h0000_0000_9000_0008, 64'h0000_0000_0000_A001);
        do_miss("rep_evict", 64'h0000_0000_9000_0000, 64'h0000_0000_0000_B000, 1'b0, 0, 1'b0);

        // Flush coincident with a fill drops the fill.
        do_miss("flfill", 64'h0000_0000_B000_0008, 64'h0000_0000_0000_3333, 1'b0, 0, 1'b1);
        do_miss("flmiss", 64'h0000_0000_B000_0008, 64'h0000_0000_0000_4444, 1'b0, 0, 1'b0);

        // Timeout: error pulse after 8 MEM_WAIT cycles, then drain and a queued walk.
        issue(64'h0000_0000_A000_0000);
        step();
        check("tmo_mreq", {63'd0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check("tmo_early", {63'd0, ptw_ready}, 64'd0);
        step();
        check("tmo_rdy", {63'd0, ptw_ready}, 64'd1);
        check("tmo_err", {63'd0, ptw_err}, 64'd1);
        check("tmo_data", ptw_data, 64'd0);
        step();
        check("drain_rdy", {63'd0, ptw_ready}, 64'd0);
        check("drain_busy", {63'd0, busy}, 64'd1);
        ptw_req  = 1'b1;
        ptw_addr = GARBAGE;
        step();
        ptw_req        = 1'b0;
        ptw_addr       = 64'h0000_0000_B000_0008;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0000_0000_0000_0BAD;
        step();
        mem_resp_valid = 1'b0;
        check("drain_idle", {63'd0, busy}, 64'd0);
        check("drain_nordy", {63'd0, ptw_ready}, 64'd0);
        step();
        check("pend_busy", {63'd0, busy}, 64'd1);
        step();
        check("pend_rdy", {63'd0, ptw_ready}, 64'd1);
        check("pend_data", ptw_data, 64'h0000_0000_0000_4444);
        check("pend_err", {63'd0, ptw_err}, 64'd0);
        check("pend_nomem", {63'd0, mem_req_valid}, 64'd0);
        step();

        // Async reset in MEM_WAIT, then a stray response must be ignored.
        issue(64'h0000_0000_C000_0000);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("ar_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy0", {63'd0, busy}, 64'd0);
        check("ar_data0", ptw_data, 64'd0);
        check("ar_err0", {63'd0, ptw_err}, 64'd0);
        check("ar_mreq0", {63'd0, mem_req_valid}, 64'd0);
        check("ar_maddr0", mem_req_addr, 64'd0);
        check("ar_rdy0", {63'd0, ptw_ready}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0000_0000_0000_7777;
        step();
        mem_resp_valid = 1'b0;
        check("stray_rdy", {63'd0, ptw_ready}, 64'd0);
        step();
        check("stray_rdy2", {63'd0, ptw_ready}, 64'd0);
        check("stray_busy", {63'd0, busy}, 64'd0);
        check("stray_data", ptw_data, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
